// File: rtl/bcd_time_display.sv
// Purpose: BCD timekeeper (MM:SS or HH:MM:SS) with validated load, alarm edge detect and a blinking 7-segment scan.
// Latency: time advances every TICK_DIV cycles; load/reject, alarm_hit and anode/seg are registered and appear one cycle later.
// Backpressure: none; a load is either taken or rejected (load_err) in the cycle it is presented.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   run               - advance time; 0 freezes time and the prescaler
//   load, load_time   - one-cycle load request with BCD time (digit 0 = seconds units at [3:0])
//   alarm_time, alarm_en - alarm compare value and enable
//   edit_sel          - one-hot digit to blink, all-zero for none
//   time_out          - current BCD time
//   sec_tick, load_err, alarm_hit - single-cycle event pulses
//   anode, seg        - active-low digit enables, active-high {g,f,e,d,c,b,a}
module bcd_time_display #(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 100_000_000,
  parameter int SCAN_DIV  = 65_536,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_time,
  input  logic [4*DIGITS-1:0] alarm_time,
  input  logic                alarm_en,
  input  logic [DIGITS-1:0]   edit_sel,
  output logic [4*DIGITS-1:0] time_out,
  output logic                sec_tick,
  output logic                load_err,
  output logic                alarm_hit,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          seg
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int IW = $clog2(DIGITS);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  if (DIGITS != 4 && DIGITS != 6) begin : g_bad_digits
    $error("bcd_time_display: DIGITS must be 4 or 6");
  end

  // Both helpers work on a 24-bit image; a 4-digit time is zero-extended,
  // so its (empty) hours field is always legal and the carry out of the
  // minutes-tens digit is simply dropped on truncation, giving 59:59 -> 00:00.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (t[4*i +: 4] == (((i % 2) == 1) ? 4'd5 : 4'd9)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = t[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    // Hours roll as a pair: 23 -> 00, otherwise ordinary BCD carry.
    if (c) begin
      if (t[23:16] == 8'h23)       r[23:16] = 8'h00;
      else if (t[19:16] == 4'd9)   r[23:16] = {t[23:20] + 4'd1, 4'd0};
      else                         r[19:16] = t[19:16] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (t[4*i +: 4] > (((i % 2) == 1) ? 4'd5 : 4'd9)) ok = 1'b0;
    end
    if (t[23:20] > 4'd2)                         ok = 1'b0;
    if (t[19:16] > 4'd9)                         ok = 1'b0;
    if (t[23:20] == 4'd2 && t[19:16] > 4'd3)     ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b0111111;
      4'd1:    seg_enc = 7'b0000110;
      4'd2:    seg_enc = 7'b1011011;
      4'd3:    seg_enc = 7'b1001111;
      4'd4:    seg_enc = 7'b1100110;
      4'd5:    seg_enc = 7'b1101101;
      4'd6:    seg_enc = 7'b1111101;
      4'd7:    seg_enc = 7'b0000111;
      4'd8:    seg_enc = 7'b1111111;
      4'd9:    seg_enc = 7'b1101111;
      default: seg_enc = 7'b0000000;
    endcase
  endfunction

  logic [PW-1:0] presc;
  logic [W-1:0]  time_inc;
  logic          load_ok;
  logic          match;
  logic          match_q;

  assign time_inc = W'(bcd_inc(24'(time_out)));
  assign load_ok  = bcd_ok(24'(load_time));
  assign match    = alarm_en & (time_out == alarm_time);

  // Timekeeping: a valid load wins over a coincident tick; a rejected load
  // leaves the prescaler and time path running as if no load were present.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_out  <= '0;
      presc     <= '0;
      sec_tick  <= 1'b0;
      load_err  <= 1'b0;
      match_q   <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      load_err  <= load & ~load_ok;
      match_q   <= match;
      alarm_hit <= match & ~match_q;
      if (load && load_ok) begin
        time_out <= load_time;
        presc    <= '0;
      end else if (run) begin
        if (presc == TICK_LAST) begin
          presc    <= '0;
          time_out <= time_inc;
          sec_tick <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  logic [SW-1:0]     scan_cnt;
  logic [IW-1:0]     scan_idx;
  logic [BW-1:0]     blink_cnt;
  logic              blink_ph;
  logic [3:0]        cur_dig;
  logic              cur_edit;
  logic [DIGITS-1:0] anode_nxt;

  // Digit mux is a compare loop rather than a variable part-select so an
  // unused index code (6 and 7 when DIGITS=6) can never address past time_out.
  always_comb begin
    cur_dig   = 4'd0;
    cur_edit  = 1'b0;
    anode_nxt = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        cur_dig      = time_out[4*i +: 4];
        cur_edit     = edit_sel[i];
        anode_nxt[i] = 1'b0;
      end
    end
    if (blink_ph && cur_edit) anode_nxt = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      anode     <= '1;
      seg       <= 7'b0000000;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      anode <= anode_nxt;
      seg   <= seg_enc(cur_dig);
    end
  end

endmodule

// File: doc/bcd_time_display.md
# bcd_time_display

Parametrised timekeeping and display core for the alarm-clock front panel. It replaces the ad-hoc MM:SS counter and 4-digit anode scan with one block. The block keeps time in BCD at 4 digits (MM:SS) or 6 digits (HH:MM:SS), accepts validated time loads, and flags alarm matches. It also multiplexes the digits onto the 7-segment display, blinking the digit currently being edited.

## Interface
Parameters:
- DIGITS, 4: digit count. Legal values are 4 (MM:SS) and 6 (HH:MM:SS); any other value is an elaboration error.
- TICK_DIV, 100_000_000: clk cycles per second tick (≥2).
- SCAN_DIV, 65_536: clk cycles each digit is driven (≥1).
- BLINK_DIV, 25_000_000: clk cycles per blink half-period (≥1).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = timekeeping advances; 0 = time and prescaler frozen.
- load  in  1  one-cycle request to load load_time.
- load_time  in  4*DIGITS  BCD time to load; digit 0 = seconds units, at bits [3:0].
- alarm_time  in  4*DIGITS  BCD alarm time, same layout.
- alarm_en  in  1  enables alarm_hit.
- edit_sel  in  DIGITS  one-hot digit to blink; all-zero = no blink.
- time_out  out  4*DIGITS  current BCD time (registered).
- sec_tick  out  1  one-cycle pulse on each time advance.
- load_err  out  1  one-cycle pulse when a load is rejected.
- alarm_hit  out  1  one-cycle pulse on entering alarm match.
- anode  out  DIGITS  active-low digit enables; anode[0] = rightmost digit.
- seg  out  7  active-high segments {g,f,e,d,c,b,a}; 0 = 0111111, 8 = 1111111.

## Operation
- **Digit limits:** each digit counts 0–9, except:
  - seconds tens and minutes tens count 0–5;
  - hours (DIGITS=6) run 00–23 as a pair.
- **Prescaler:** counts 0..TICK_DIV-1 while run=1. On the cycle it equals TICK_DIV-1:
  - it returns to 0;
  - time_out increments by one second with BCD ripple carry;
  - sec_tick=1 in that same cycle.
- **Wrap:** 59:59 → 00:00 (DIGITS=4); 23:59:59 → 00:00:00 (DIGITS=6). Wrap asserts sec_tick only; no other flag.
- **Load priority:** load takes priority over a coincident tick.
  - Valid load_time (every digit within its limit, hours ≤ 23): time_out ← load_time, prescaler ← 0, no sec_tick.
  - Invalid load_time: time_out is unchanged, load_err=1 for one cycle, and the prescaler continues as if load were 0.
- **Alarm:** match = alarm_en & (time_out == alarm_time), registered into match_q.
  - alarm_hit = match & ~match_q, so it fires once per entry into match.
  - Entry by load fires it as well.
  - It stays low while the match persists (run=0) and re-arms after the match drops.
- **Scan:** digit index advances every SCAN_DIV cycles, 0→1→…→DIGITS-1→0.
  - For index i: anode = all ones except bit i = 0; seg = encoding of time_out digit i.
  - Codes >9 give seg = 0000000 (cannot occur after validation).
- **Blink:** blink phase toggles every BLINK_DIV cycles. While phase=1 and edit_sel[i]=1 for the driven index i, anode = all ones (digit blank). Other digits are unaffected.
- **Reset values:**
  - time_out = 0, prescaler = 0, sec_tick = 0, load_err = 0, alarm_hit = 0, match_q = 0;
  - scan index = 0, scan count = 0, blink phase = 0, blink count = 0;
  - anode = all ones, seg = 0000000.

## Timing
- All state changes on the rising edge of clk. Reset is synchronous and overrides everything, including load, in the same cycle.
- Reset asserted mid-operation clears state at the next edge; no partial tick survives.
- time_out updates on the edge after the prescaler reaches TICK_DIV-1 (with run=1). First advance after reset release: exactly TICK_DIV cycles. Period thereafter: TICK_DIV cycles.
- sec_tick and load_err are registered and asserted coincident with the resulting time_out value or load rejection.
- alarm_hit asserts one cycle after time_out first equals alarm_time (compare of registered time, then edge detect).
- anode/seg are registered: they reflect the index and digit value one cycle after the index changes. First valid anode appears 1 cycle after reset release.
- run=0 with load=1: the load is still accepted. The prescaler is cleared to 0 and stays frozen at 0.
- A change of alarm_en or alarm_time can create a match entry without a time change; alarm_hit fires on it.

## Test plan
- **Reset and scan:** DIGITS=4, SCAN_DIV=2, time 00:00, reset then release → anode cycles 1110,1101,1011,0111 every 2 cycles; seg = 0111111 on each digit.
- **Tick and wrap:** TICK_DIV=4, load 59:58, run=1 → time_out 59:59 after 4 cycles, then 00:00 after 8; sec_tick high exactly in those 2 cycles. DIGITS=6 from 23:59:59 → 00:00:00.
- **Load validation:** load 5A:00, then 60:00 → both rejected, load_err pulses once each, time unchanged. Load 12:34 coincident with a tick → time_out 12:34, no sec_tick, next advance 4 cycles later.
- **Alarm:** alarm 00:03, alarm_en=1, start 00:00 → alarm_hit single pulse one cycle after time_out=00:03. Set run=0 at 00:03 → no further pulses. Toggle alarm_en 0→1 → one more pulse.
- **Blink:** BLINK_DIV=8, edit_sel=0010 → digit 1 blanked (anode 1111) during phase=1 windows and shown during phase=0; other digits always shown.
- **Mid-operation reset:** assert reset while prescaler=2 and load=1 → next edge all outputs at reset values, load ignored.
